// File: rtl/ata_pio_arb_pkg.sv
// Shared types and constants for the two-requester ATA PIO arbiter.
// The optional watchdog is enabled by defining ATA_PIO_ARB_TIMEOUT_EN.
package ata_pio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    localparam logic REQ0_IDX = 1'b0;
    localparam logic REQ1_IDX = 1'b1;

    localparam int DEF_TO_WIDTH  = 8;
    localparam int DEF_TO_CYCLES = 200;

    // Round-robin pick: a lone request wins outright; on a tie the requester
    // that was not granted last wins.
    function automatic logic rr_pick(input logic sel0, input logic sel1, input logic last);
        logic pick;
        if (sel0 && sel1) begin
            pick = ~last;
        end else if (sel1) begin
            pick = REQ1_IDX;
        end else begin
            pick = REQ0_IDX;
        end
        return pick;
    endfunction

endpackage

// File: rtl/ata_pio_arb_wdog.sv
// BUSY-phase watchdog for ata_pio_arbiter; only instantiated when
// ATA_PIO_ARB_TIMEOUT_EN is defined.
module ata_pio_arb_wdog #(
    parameter int TO_WIDTH  = 8,
    parameter int TO_CYCLES = 200
) (
    input  logic CLK_I,
    input  logic RST_I,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_WIDTH-1:0] count;

    // count holds the number of BUSY cycles already completed, so the
    // TO_CYCLES-th BUSY cycle is the one that sees TO_CYCLES-1.
    assign expired = enable && (count == TO_WIDTH'(TO_CYCLES - 1));

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + TO_WIDTH'(1);
        end
    end

endmodule

// File: rtl/ata_pio_arbiter.sv
// Two-requester round-robin front end for a single ATA PIO engine.
// Define ATA_PIO_ARB_TIMEOUT_EN to abort transfers the engine never acknowledges.
module ata_pio_arbiter
    import ata_pio_arb_pkg::*;
#(
    parameter int TO_WIDTH  = DEF_TO_WIDTH,
    parameter int TO_CYCLES = DEF_TO_CYCLES
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        REQ0_SEL,
    input  logic        REQ0_WE,
    input  logic [3:0]  REQ0_ADR,
    input  logic [15:0] REQ0_DAT,
    output logic        REQ0_ACK,
    output logic        REQ0_ERR,
    output logic [15:0] REQ0_Q,
    input  logic        REQ1_SEL,
    input  logic        REQ1_WE,
    input  logic [3:0]  REQ1_ADR,
    input  logic [15:0] REQ1_DAT,
    output logic        REQ1_ACK,
    output logic        REQ1_ERR,
    output logic [15:0] REQ1_Q,
    output logic        PIOsel,
    input  logic        PIOack,
    output logic        PIOwe,
    output logic [3:0]  PIOadr,
    output logic [15:0] PIOd,
    input  logic [15:0] PIOq,
    output logic        BUSY_O,
    output arb_state_t  state_dbg
);

    if (TO_CYCLES < 1 || TO_CYCLES >= (2 ** TO_WIDTH)) begin : g_bad_cfg
        $error("ata_pio_arbiter: TO_CYCLES must lie in [1, 2**TO_WIDTH)");
    end

    // Handshake: a requester raises SEL with a stable command and holds it
    // until it sees a one-cycle ACK (done, Q valid) or ERR (aborted); the
    // engine sees PIOsel held with a stable command until its one-cycle PIOack.
    arb_state_t  state;
    logic        grant;
    logic        last_grant;
    logic [15:0] q_reg;
    logic [1:0]  err_r;
    logic        expired;
    logic        pick;
    logic        take;

    assign pick = rr_pick(REQ0_SEL, REQ1_SEL, last_grant);
    // The abort cycle is skipped so a requester still holding SEL while it
    // observes ERR is not immediately re-granted.
    assign take = (state == ST_IDLE) && (REQ0_SEL || REQ1_SEL) && (err_r == 2'b00);

    assign BUSY_O    = (state != ST_IDLE);
    assign state_dbg = state;
    assign REQ0_Q    = q_reg;
    assign REQ1_Q    = q_reg;

`ifdef ATA_PIO_ARB_TIMEOUT_EN
    ata_pio_arb_wdog #(
        .TO_WIDTH  (TO_WIDTH),
        .TO_CYCLES (TO_CYCLES)
    ) u_wdog (
        .CLK_I   (CLK_I),
        .RST_I   (RST_I),
        .clear   (take),
        .enable  (state == ST_BUSY),
        .expired (expired)
    );
    assign REQ0_ERR = err_r[0];
    assign REQ1_ERR = err_r[1];
`else
    assign expired  = 1'b0;
    assign REQ0_ERR = 1'b0;
    assign REQ1_ERR = 1'b0;
`endif

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state      <= ST_IDLE;
            grant      <= REQ0_IDX;
            last_grant <= REQ1_IDX;
            q_reg      <= '0;
            err_r      <= '0;
            REQ0_ACK   <= 1'b0;
            REQ1_ACK   <= 1'b0;
            PIOsel     <= 1'b0;
            PIOwe      <= 1'b0;
            PIOadr     <= '0;
            PIOd       <= '0;
        end else begin
            REQ0_ACK <= 1'b0;
            REQ1_ACK <= 1'b0;
            err_r    <= '0;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        grant  <= pick;
                        PIOwe  <= (pick == REQ1_IDX) ? REQ1_WE  : REQ0_WE;
                        PIOadr <= (pick == REQ1_IDX) ? REQ1_ADR : REQ0_ADR;
                        PIOd   <= (pick == REQ1_IDX) ? REQ1_DAT : REQ0_DAT;
                        PIOsel <= 1'b1;
                        state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A PIOack landing in the expiry cycle still completes normally.
                    if (PIOack) begin
                        q_reg    <= PIOq;
                        PIOsel   <= 1'b0;
                        REQ0_ACK <= (grant == REQ0_IDX);
                        REQ1_ACK <= (grant == REQ1_IDX);
                        state    <= ST_DONE;
                    end else if (expired) begin
                        PIOsel     <= 1'b0;
                        err_r[0]   <= (grant == REQ0_IDX);
                        err_r[1]   <= (grant == REQ1_IDX);
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    last_grant <= grant;
                    state      <= ST_IDLE;
                end
                default: begin
                    PIOsel <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ata_pio_arbiter.sv
// Directed plus randomized bench for ata_pio_arbiter with a transaction-level
// round-robin model; covers ATA_PIO_ARB_TIMEOUT_EN builds as well.
module tb_ata_pio_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel [2];
    logic        we  [2];
    logic [3:0]  adr [2];
    logic [15:0] dat [2];
    logic        REQ0_ACK, REQ0_ERR, REQ1_ACK, REQ1_ERR;
    logic [15:0] REQ0_Q, REQ1_Q;
    logic        PIOsel, PIOack, PIOwe, BUSY_O;
    logic [3:0]  PIOadr;
    logic [15:0] PIOd, PIOq;
    ata_pio_arb_pkg::arb_state_t state_dbg;

    // Transaction-level model: who is waiting, their commands, last winner.
    logic        m_pend [2];
    logic        m_we   [2];
    logic [3:0]  m_adr  [2];
    logic [15:0] m_dat  [2];
    int          m_last;

    int checks = 0;
    int errors = 0;
    int w;

    always #5 clk = ~clk;

    ata_pio_arbiter #(.TO_WIDTH(8), .TO_CYCLES(10)) dut (
        .CLK_I(clk), .RST_I(rst),
        .REQ0_SEL(sel[0]), .REQ0_WE(we[0]), .REQ0_ADR(adr[0]), .REQ0_DAT(dat[0]),
        .REQ0_ACK(REQ0_ACK), .REQ0_ERR(REQ0_ERR), .REQ0_Q(REQ0_Q),
        .REQ1_SEL(sel[1]), .REQ1_WE(we[1]), .REQ1_ADR(adr[1]), .REQ1_DAT(dat[1]),
        .REQ1_ACK(REQ1_ACK), .REQ1_ERR(REQ1_ERR), .REQ1_Q(REQ1_Q),
        .PIOsel(PIOsel), .PIOack(PIOack), .PIOwe(PIOwe), .PIOadr(PIOadr),
        .PIOd(PIOd), .PIOq(PIOq), .BUSY_O(BUSY_O), .state_dbg(state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 2; i++) begin
            sel[i]    = 1'b0;
            m_pend[i] = 1'b0;
        end
        m_last = 1;
    endtask

    task automatic post(input int i, input logic w_i, input logic [3:0] a_i, input logic [15:0] d_i);
        sel[i] = 1'b1;
        we[i]  = w_i;
        adr[i] = a_i;
        dat[i] = d_i;
        m_pend[i] = 1'b1;
        m_we[i]   = w_i;
        m_adr[i]  = a_i;
        m_dat[i]  = d_i;
    endtask

    task automatic post_rand(input int i);
        post(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom));
    endtask

    // One full transfer from the grant edge to the following IDLE cycle.
    task automatic transfer(input int delay, input logic [15:0] q, input bit drop_mid,
                            input bit add_other, output int winner);
        int wn;
        int ot;
        if (m_pend[0] && m_pend[1]) wn = (m_last == 0) ? 1 : 0;
        else if (m_pend[1])         wn = 1;
        else                        wn = 0;
        ot = 1 - wn;
        tick;
        chk("grant_piosel", PIOsel, 1);
        chk("grant_busy", BUSY_O, 1);
        chk("grant_we", PIOwe, m_we[wn]);
        chk("grant_adr", PIOadr, m_adr[wn]);
        chk("grant_dat", PIOd, m_dat[wn]);
        for (int k = 0; k < delay; k++) begin
            if (add_other && k == 0 && !m_pend[ot]) post_rand(ot);
            if (drop_mid && k == delay - 1) sel[wn] = 1'b0;
            tick;
            chk("busy_piosel", PIOsel, 1);
            chk("busy_we", PIOwe, m_we[wn]);
            chk("busy_adr", PIOadr, m_adr[wn]);
            chk("busy_dat", PIOd, m_dat[wn]);
            chk("busy_noack", {REQ1_ACK, REQ0_ACK}, 0);
        end
        PIOack = 1'b1;
        PIOq   = q;
        tick;
        PIOack = 1'b0;
        PIOq   = 16'($urandom);
        chk("done_ack", {REQ1_ACK, REQ0_ACK}, (wn == 1) ? 2'b10 : 2'b01);
        chk("done_err", {REQ1_ERR, REQ0_ERR}, 0);
        chk("done_q", (wn == 1) ? REQ1_Q : REQ0_Q, q);
        chk("done_piosel", PIOsel, 0);
        chk("done_busy", BUSY_O, 1);
        sel[wn]    = 1'b0;
        m_pend[wn] = 1'b0;
        m_last     = wn;
        tick;
        chk("idle_busy", BUSY_O, 0);
        chk("idle_ack", {REQ1_ACK, REQ0_ACK}, 0);
        winner = wn;
    endtask

    initial begin
        rst    = 1'b1;
        PIOack = 1'b0;
        PIOq   = '0;
        for (int i = 0; i < 2; i++) begin
            we[i] = 1'b0; adr[i] = '0; dat[i] = '0;
        end
        model_reset();

        // Reset values
        tick; tick;
        chk("rst_piosel", PIOsel, 0);
        chk("rst_busy", BUSY_O, 0);
        chk("rst_ack", {REQ1_ACK, REQ0_ACK}, 0);
        chk("rst_err", {REQ1_ERR, REQ0_ERR}, 0);
        chk("rst_cmd", {PIOwe, PIOadr, PIOd}, 0);
        chk("rst_q", {REQ1_Q, REQ0_Q}, 0);
        chk("rst_state", state_dbg, ata_pio_arb_pkg::ST_IDLE);
        rst = 1'b0;
        tick;

        // Stray PIOack while idle
        PIOack = 1'b1;
        tick;
        PIOack = 1'b0;
        chk("stray_ack", {REQ1_ACK, REQ0_ACK, REQ1_ERR, REQ0_ERR}, 0);
        chk("stray_busy", BUSY_O, 0);
        chk("stray_piosel", PIOsel, 0);
        tick;
        chk("stray_busy2", BUSY_O, 0);

        // REQ0 read of register 7, engine answers 5 cycles after PIOsel
        post(0, 1'b0, 4'h7, 16'h0000);
        transfer(5, 16'h50A0, 1'b0, 1'b0, w);
        chk("r031_winner", w, 0);
        chk("r031_adr", PIOadr, 4'h7);
        chk("r031_we", PIOwe, 0);

        // Asynchronous reset in the middle of a REQ1 transfer
        post(1, 1'b1, 4'h1, 16'h1234);
        tick;
        chk("r034_piosel_pre", PIOsel, 1);
        #2 rst = 1'b1;
        #1;
        chk("r034_piosel_async", PIOsel, 0);
        chk("r034_busy_async", BUSY_O, 0);
        chk("r034_noack", {REQ1_ACK, REQ0_ACK}, 0);
        model_reset();
        tick;
        rst = 1'b0;
        tick;
        chk("r034_idle", BUSY_O, 0);

        // Simultaneous requests after reset, then alternation
        post(0, 1'b0, 4'h8, 16'h0);
        post(1, 1'b0, 4'h9, 16'h0);
        transfer(1, 16'hA001, 1'b0, 1'b0, w);
        chk("r032_first", w, 0);
        post(0, 1'b1, 4'hA, 16'h5555);
        transfer(2, 16'hA002, 1'b0, 1'b0, w);
        chk("r032_second", w, 1);
        post(1, 1'b1, 4'hB, 16'h6666);
        transfer(0, 16'hA003, 1'b0, 1'b0, w);
        chk("r032_third", w, 0);
        transfer(3, 16'hA004, 1'b0, 1'b0, w);
        chk("r032_fourth", w, 1);

        // REQ1 write held stable while REQ0 arrives mid-transfer
        post(1, 1'b1, 4'h2, 16'hBEEF);
        transfer(4, 16'h0F0F, 1'b0, 1'b1, w);
        chk("r033_first", w, 1);
        transfer(1, 16'h1111, 1'b0, 1'b0, w);
        chk("r033_second", w, 0);

        // Engine never acknowledges
        post(0, 1'b0, 4'h3, 16'h0);
        tick;
        chk("to_piosel_0", PIOsel, 1);
`ifdef ATA_PIO_ARB_TIMEOUT_EN
        for (int k = 1; k < 10; k++) begin
            tick;
            chk("to_piosel_hold", PIOsel, 1);
            chk("to_no_err_yet", {REQ1_ERR, REQ0_ERR}, 0);
        end
        tick;
        chk("to_piosel_drop", PIOsel, 0);
        chk("to_err", {REQ1_ERR, REQ0_ERR}, 2'b01);
        chk("to_noack", {REQ1_ACK, REQ0_ACK}, 0);
        sel[0] = 1'b0;
        m_pend[0] = 1'b0;
        m_last = 0;
        tick;
        chk("to_err_clear", {REQ1_ERR, REQ0_ERR}, 0);
        chk("to_idle", BUSY_O, 0);
        chk("to_no_regrant", PIOsel, 0);
`else
        for (int k = 1; k < 40; k++) begin
            tick;
            chk("noto_piosel_hold", PIOsel, 1);
            chk("noto_no_err", {REQ1_ERR, REQ0_ERR}, 0);
            chk("noto_noack", {REQ1_ACK, REQ0_ACK}, 0);
        end
        rst = 1'b1;
        model_reset();
        tick;
        rst = 1'b0;
        tick;
        chk("noto_reset_idle", BUSY_O, 0);
`endif

        // Randomized traffic against the round-robin model
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 2; i++)
                if (!m_pend[i] && $urandom_range(0, 1) == 1) post_rand(i);
            if (!m_pend[0] && !m_pend[1]) post_rand(int'($urandom_range(0, 1)));
            transfer(int'($urandom_range(0, 5)), 16'($urandom),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ata_pio_arbiter.md
ATA_PIO_ARBITER -- requirements
Module: ata_pio_arbiter

Interface
REQ-001 Parameter TO_WIDTH, default 8: timeout counter width.
REQ-002 Parameter TO_CYCLES, default 200: cycles BUSY waits for PIOack before abort; must be <2**TO_WIDTH.
REQ-003 CLK_I  input  1  single clock, all state on rising edge.
REQ-004 RST_I  input  1  reset, asynchronous, active-high.
REQ-005 REQx_SEL (x=0,1)  input  1  requester x wants one PIO transfer; held until REQx_ACK or REQx_ERR.
REQ-006 REQx_WE  input  1  1=write, 0=read.
REQ-007 REQx_ADR  input  4  {CS1 select, DA[2:0]}.
REQ-008 REQx_DAT  input  16  write data.
REQ-009 REQx_ACK  output  1  one-cycle completion pulse.
REQ-010 REQx_ERR  output  1  one-cycle timeout-abort pulse.
REQ-011 REQx_Q  output  16  read data, valid when REQx_ACK=1.
REQ-012 PIOsel  output  1  transfer request to PIO engine, held until PIOack.
REQ-013 PIOack  input  1  one-cycle engine completion pulse.
REQ-014 PIOwe / PIOadr / PIOd  output  1/4/16  latched command to engine.
REQ-015 PIOq  input  16  engine read data, valid with PIOack.
REQ-016 BUSY_O  output  1  high when state is not IDLE.

Function
REQ-017 FSM states IDLE, BUSY, DONE; one requester granted at a time.
REQ-018 IDLE: if any REQx_SEL=1, latch winner's WE/ADR/DAT into PIOwe/PIOadr/PIOd, record grant index, go BUSY; PIOsel rises the next cycle (latency 1).
REQ-019 Arbitration round-robin: on simultaneous requests the requester not granted last wins; single request wins unconditionally.
REQ-020 BUSY: PIOsel=1, command outputs stable; on PIOack, register PIOq, go DONE.
REQ-021 DONE: PIOsel=0, REQx_ACK=1 for granted x only, REQx_Q = registered data, last-grant pointer updated, go IDLE; total latency SEL->ACK = PIOack cycle + 1.
REQ-022 IDLE is not re-entered with a grant in the DONE cycle, so a requester dropping SEL on ACK causes no re-grant.
REQ-023 Requester dropping SEL during BUSY: transfer still completes, ACK still pulsed once.
REQ-024 PIOack outside BUSY is ignored.
REQ-025 REQx_ACK and REQx_ERR never both 1; never pulsed for the ungranted requester.

Reset
REQ-026 RST_I=1 immediately forces IDLE, PIOsel=0, all ACK/ERR=0, BUSY_O=0, PIOwe=0, PIOadr=0, PIOd=0, REQx_Q=0, last-grant pointer=1 (requester 0 wins first), timeout counter=0, including mid-transfer.

Configuration
REQ-027 Macro ATA_PIO_ARB_TIMEOUT_EN defined: counter clears on entering BUSY, increments each BUSY cycle; at TO_CYCLES without PIOack, drop PIOsel, pulse REQx_ERR for one cycle, update pointer, go IDLE; PIOack in the same cycle as expiry wins (normal DONE).
REQ-028 Macro undefined: no counter logic, REQx_ERR tied 0, BUSY waits indefinitely.

Structure
REQ-029 Package ata_pio_arb_pkg holds FSM state encoding, requester index constants, default TO_CYCLES.
REQ-030 Timeout counter is sub-module ata_pio_arb_wdog, instantiated only under ATA_PIO_ARB_TIMEOUT_EN.

Verification
REQ-031 REQ0 read ADR=4'h7, engine acks 5 cycles after PIOsel with PIOq=16'h50A0 -> PIOadr=7, PIOwe=0, REQ0_ACK one cycle after PIOack, REQ0_Q=16'h50A0.
REQ-032 REQ0 and REQ1 assert same cycle after reset -> REQ0 served first, REQ1 next; repeat both -> order alternates 1,0.
REQ-033 REQ1 write DAT=16'hBEEF, REQ0 asserts mid-transfer -> PIOd stays 16'hBEEF until PIOack; REQ0 granted only after DONE.
REQ-034 RST_I pulsed during BUSY -> PIOsel low same cycle asynchronously, no ACK, next request granted normally to REQ0.
REQ-035 With ATA_PIO_ARB_TIMEOUT_EN, TO_CYCLES=10, no PIOack -> PIOsel drops after 10 BUSY cycles, REQ0_ERR pulse, REQ0_ACK never; without macro PIOsel stays high.
REQ-036 Stray PIOack in IDLE -> no ACK/ERR outputs, state unchanged.
